// File: rtl/mult_div_unit_if.sv
// Bus between the control unit / register bank and the HI/LO multiply-divide unit.
// Handshake: start is taken only on a clock edge where busy is low; once taken, busy
// stays high until the edge that raises done, and done (with div_by_zero) is high for
// exactly one cycle. hi_we/lo_we are honoured only while busy is low and start is low.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] write_data;
   logic             hi_lo_sel;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] result;
   logic [1:0]       fsm_state;

   modport master (
      output start, op, operand_a, operand_b, hi_we, lo_we, write_data, hi_lo_sel,
      input  busy, done, div_by_zero, hi, lo, result, fsm_state
   );

   modport slave (
      input  start, op, operand_a, operand_b, hi_we, lo_we, write_data, hi_lo_sel,
      output busy, done, div_by_zero, hi, lo, result, fsm_state
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, followed by a sign-fix cycle that writes HI/LO.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic           clock,
   input  logic           reset_n,
   mult_div_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q;
   logic               sign_a_q, sign_b_q;
   logic [WIDTH-1:0]   opnd_q;     // multiplicand magnitude, or divisor magnitude
   logic [WIDTH-1:0]   a_raw_q;    // dividend as presented, returned on divide by zero
   logic [2*WIDTH-1:0] acc_q;      // multiply: {partial, multiplier}; divide: {rem, quo}
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q, dbz_q;

   // Operand magnitudes; only signed ops take absolute values
   logic             accept, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   assign accept = (state_q == IDLE) && bus.start;
   assign a_neg  = bus.op[0] & bus.operand_a[WIDTH-1];
   assign b_neg  = bus.op[0] & bus.operand_b[WIDTH-1];
   assign a_abs  = a_neg ? -bus.operand_a : bus.operand_a;
   assign b_abs  = b_neg ? -bus.operand_b : bus.operand_b;

   // One shift-add multiply step: add multiplicand into the top half, shift right
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring divide step: shift next dividend bit into the remainder, trial subtract
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
   assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   // Sign correction of the finished magnitudes
   logic               div_zero, mul_neg, quo_neg, rem_neg;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   assign div_zero = op_q[1] && (opnd_q == '0);
   assign mul_neg  = (op_q == 2'b01) && (sign_a_q ^ sign_b_q);
   assign quo_neg  = (op_q == 2'b11) && (sign_a_q ^ sign_b_q);
   assign rem_neg  = (op_q == 2'b11) && sign_a_q;
   assign prod     = mul_neg ? -acc_q : acc_q;

   // Select the HI/LO values written in FIX
   always_comb begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (div_zero) begin
         fix_hi = a_raw_q;
         fix_lo = '1;
      end else if (op_q[1]) begin
         fix_hi = rem_neg ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         fix_lo = quo_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state: accept in IDLE, 32 iterations in CALC, one fix-up cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CALC;
         CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch and iteration datapath
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opnd_q   <= '0;
         a_raw_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (accept) begin
         op_q     <= bus.op;
         sign_a_q <= a_neg;
         sign_b_q <= b_neg;
         opnd_q   <= bus.op[1] ? b_abs : a_abs;
         a_raw_q  <= bus.operand_a;
         acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
         cnt_q    <= '0;
      end else if (state_q == CALC) begin
         acc_q <= op_q[1] ? div_next : mul_next;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // HI/LO registers and completion pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= (state_q == FIX);
         dbz_q  <= (state_q == FIX) && div_zero;
         if (state_q == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end else if ((state_q == IDLE) && !bus.start) begin
            if (bus.hi_we) hi_q <= bus.write_data;
            if (bus.lo_we) lo_q <= bus.write_data;
         end
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.result      = bus.hi_lo_sel ? hi_q : lo_q;
   assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: driver tasks issue operations and push the
// hand-computed {div_by_zero, hi, lo}; a monitor pops and compares on every done.
module tb_mult_div_unit;
   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   logic [64:0] exp_q[$];

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest expected result
   always @(negedge clock) begin
      if (reset_n && bus.done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h with no operation pending", bus.hi, bus.lo);
         end else begin
            logic [64:0] e;
            e = exp_q.pop_front();
            if ({bus.div_by_zero, bus.hi, bus.lo} !== e) begin
               errors++;
               $display("FAIL result: got dbz=%0b hi=0x%08h lo=0x%08h expected dbz=%0b hi=0x%08h lo=0x%08h",
                        bus.div_by_zero, bus.hi, bus.lo, e[64], e[63:32], e[31:0]);
            end
         end
      end
   end

   // Driver: present an operation for one edge (E0); optionally assert lo_we alongside
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input bit push, input bit with_lo_we);
      @(negedge clock);
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      if (with_lo_we) begin
         bus.lo_we      = 1'b1;
         bus.write_data = 32'hFFFF_0000;
      end
      if (push) exp_q.push_back({ed, eh, el});
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
   endtask

   // Wait for done; expect it after exactly exp_edges more edges with busy high until then
   task automatic wait_done(input string name, input int exp_edges);
      int  lat = 0;
      int  busy_cnt = 0;
      bit  got = 0;
      while (!got && lat < 60) begin
         if (bus.busy) busy_cnt++;
         @(posedge clock);
         #1;
         lat++;
         if (bus.done) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_timeout: no done within %0d edges, expected %0d", name, lat, exp_edges);
      end else begin
         check32({name, "_latency"}, lat, exp_edges);
         check32({name, "_busy_cycles"}, busy_cnt, exp_edges);
         check32({name, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
         @(posedge clock);
         #1;
         check32({name, "_done_pulse"}, {30'b0, bus.done, bus.div_by_zero}, 32'd0);
      end
   endtask

   initial begin
      bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0;
      bus.hi_we = 0; bus.lo_we = 0; bus.write_data = 0; bus.hi_lo_sel = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check32("reset_hi", bus.hi, 32'd0);
      check32("reset_lo", bus.lo, 32'd0);
      check32("reset_flags", {29'b0, bus.busy, bus.done, bus.div_by_zero}, 32'd0);

      // Arithmetic vectors
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1, 0);
      wait_done("multu_max", 33);
      issue(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1, 0);
      wait_done("mult_neg", 33);
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1, 0);
      wait_done("div_neg", 33);
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, 0);
      wait_done("divu", 33);
      issue(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, 0);
      wait_done("div_zero", 33);
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1, 0);
      wait_done("div_ovf", 33);

      // start while busy and operand changes have no effect
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, 0);
      repeat (9) @(posedge clock);
      #1;
      bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd999; bus.operand_b = 32'd3;
      @(posedge clock);
      #1;
      bus.start = 1'b0; bus.operand_a = 32'h5555_5555;
      wait_done("ignore_start", 23);

      // MTHI while busy is ignored
      issue(2'b10, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0, 1, 0);
      repeat (4) @(posedge clock);
      #1;
      bus.hi_we = 1'b1; bus.write_data = 32'hDEAD_BEEF;
      @(posedge clock);
      #1;
      bus.hi_we = 1'b0;
      check32("hi_we_busy", bus.hi, 32'd2);
      wait_done("divu_hi_we", 28);

      // MTHI / MTLO in IDLE
      @(negedge clock);
      bus.hi_we = 1'b1; bus.write_data = 32'h0000_1234; bus.hi_lo_sel = 1'b1;
      @(posedge clock);
      #1;
      bus.hi_we = 1'b0;
      check32("mthi_hi", bus.hi, 32'h0000_1234);
      check32("mthi_result", bus.result, 32'h0000_1234);
      @(negedge clock);
      bus.lo_we = 1'b1; bus.write_data = 32'h0000_ABCD; bus.hi_lo_sel = 1'b0;
      @(posedge clock);
      #1;
      bus.lo_we = 1'b0;
      check32("mtlo_lo", bus.lo, 32'h0000_ABCD);
      check32("mtlo_result", bus.result, 32'h0000_ABCD);

      // start wins over lo_we in the same cycle; result shows old LO during busy
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, 1);
      check32("start_wins_lo", bus.lo, 32'h0000_ABCD);
      check32("busy_result_old", bus.result, 32'h0000_ABCD);
      wait_done("divu_start_wins", 33);

      // Asynchronous reset mid-operation
      issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 0, 0);
      repeat (15) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check32("async_rst_flags", {29'b0, bus.busy, bus.done, bus.div_by_zero}, 32'd0);
      check32("async_rst_hi", bus.hi, 32'd0);
      check32("async_rst_lo", bus.lo, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1, 0);
      wait_done("multu_after_rst", 33);

      repeat (40) @(posedge clock);
      check32("pending_results", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit directly downstream of the register bank.
- Consumes the RS and RT read-data buses, computes MULT/MULTU/DIV/DIVU iteratively, and holds the result in HI/LO.
- Returns HI or LO on `result` to the bank's write-data path for MFHI/MFLO.
- Control unit pulses `start` and stalls the pipeline on `busy`.

Parameters:
- WIDTH, 32, operand/HI/LO width (only 32 is supported).
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- operand_a  in  32  RS data (multiplicand / dividend)
- operand_b  in  32  RT data (multiplier / divisor)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- write_data  in  32  MTHI/MTLO data (RS)
- hi_lo_sel  in  1  1 = result shows HI, 0 = LO
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  pulses with done when a DIV/DIVU had divisor 0
- hi  out  32  HI register
- lo  out  32  LO register
- result  out  32  combinational: hi_lo_sel ? hi : lo

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0.
  - Takes effect immediately, including mid-operation: the operation is aborted and no HI/LO update occurs.
- State machine: IDLE, CALC, FIX.
  - busy = (state != IDLE), decoded from state register.
- IDLE:
  - On edge E0 with start=1: latch op, |a|, |b| and sign info, clear the partial registers and counter, go to CALC.
  - Absolute values are used only when op is signed. |0x80000000| = 0x80000000 as unsigned.
- CALC: one iteration per edge, E1..E32.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient and remainder.
  - At E32 (counter == 31): go to FIX.
- FIX, at E33:
  - Apply sign correction and write HI/LO.
  - Set done=1; set div_by_zero if applicable.
  - Go to IDLE, so busy falls at the same edge done rises.
  - done and div_by_zero clear at E34 unless a new completion occurs.
- Latency: done is high during the cycle after E33, i.e. 33 edges after start is sampled.
- A start asserted in the done cycle is accepted at E34.
- start while busy: ignored, with no queuing.
- Multiply results: HI = product[63:32], LO = product[31:0].
  - MULT negates the 64-bit product when sign(a) XOR sign(b).
- Divide results: LO = quotient, truncated toward zero; HI = remainder, sign follows the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero:
  - Same latency as a normal divide.
  - HI = operand_a as latched, LO = 0xFFFFFFFF.
  - div_by_zero=1 with done. No sign correction is applied.
- MTHI/MTLO:
  - hi_we/lo_we write write_data at the edge, only in IDLE and not in a cycle where start=1.
  - Ignored while busy or when start=1 in the same cycle (start wins).
  - hi_we and lo_we together write both registers.
- HI/LO hold their value at all times except FIX-state writes and MTHI/MTLO writes.
  - result is readable during busy but shows the old values until FIX.
- Operands are latched at start; later changes on operand_a/operand_b have no effect.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 -> LO=14, HI=2, div_by_zero=0. DIV a=5, b=0 -> HI=5, LO=0xFFFFFFFF, div_by_zero=1 for one cycle together with done.
- Start a DIVU; at E10 pulse start with new operands and toggle operand_a -> result is still that of the original operands.
- Start a DIVU; hi_we=1 mid-operation -> HI not written. After completion, hi_we=1 with write_data=0x1234 -> HI=0x1234, result=0x1234 with hi_lo_sel=1.
- Drop reset_n at E15 of a MULT -> busy, done and HI/LO go to 0 immediately without waiting for a clock. After release, a new MULTU 6×7 gives LO=42, HI=0.
